// File: rtl/dport_ext_bridge_pkg.sv
// Shared dport definitions: bus widths, tag width and address helpers.
package dport_ext_bridge_pkg;

  localparam int DPORT_TAG_W  = 11;
  localparam int DPORT_DATA_W = 32;
  localparam int DPORT_ADDR_W = 32;
  localparam int DPORT_BE_W   = 4;

  localparam logic [DPORT_BE_W-1:0] BE_ALL = 4'hF;

  // Byte address to word-aligned bus address.
  function automatic logic [DPORT_ADDR_W-1:0] word_align(input logic [DPORT_ADDR_W-1:0] addr);
    return {addr[DPORT_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dport_ext_bridge_tag_fifo.sv
// Tag FIFO for outstanding bus requests. The caller guarantees push only
// when not full and pop only when not empty; the head is read combinationally
// so the response stage can capture it on the popping edge.
module dport_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage only; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dport_ext_bridge.sv
// Bridge from the dport external request channel to an in-order
// request/grant + rvalid bus. Bus ops are tracked by tag in a FIFO;
// cache-maintenance ops are answered locally since nothing caches behind us.
module dport_ext_bridge
  import dport_ext_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DPORT_ADDR_W-1:0] mem_addr_i,
  input  logic [DPORT_DATA_W-1:0] mem_data_wr_i,
  input  logic                    mem_rd_i,
  input  logic [DPORT_BE_W-1:0]   mem_wr_i,
  input  logic                    mem_cacheable_i,
  input  logic [DPORT_TAG_W-1:0]  mem_req_tag_i,
  input  logic                    mem_invalidate_i,
  input  logic                    mem_writeback_i,
  input  logic                    mem_flush_i,
  output logic [DPORT_DATA_W-1:0] mem_data_rd_o,
  output logic                    mem_accept_o,
  output logic                    mem_ack_o,
  output logic                    mem_error_o,
  output logic [DPORT_TAG_W-1:0]  mem_resp_tag_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [DPORT_ADDR_W-1:0] bus_addr_o,
  output logic [DPORT_DATA_W-1:0] bus_wdata_o,
  output logic [DPORT_BE_W-1:0]   bus_be_o,
  input  logic                    bus_gnt_i,
  input  logic                    bus_rvalid_i,
  input  logic [DPORT_DATA_W-1:0] bus_rdata_i,
  input  logic                    bus_err_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                    bus_op, maint_op, local_op, is_write;
  logic                    bus_acc, local_acc, push, pop;
  logic [CNT_W-1:0]        count;
  logic [DPORT_TAG_W-1:0]  head_tag;

  logic                    ack_q, err_q, local_pend_q;
  logic [DPORT_DATA_W-1:0] rdata_q;
  logic [DPORT_TAG_W-1:0]  tag_q;

  // Cacheability has no meaning without a cache; low address bits are dropped.
  logic unused_inputs;
  assign unused_inputs = ^{mem_cacheable_i, mem_addr_i[1:0]};

  // Op decode: any read or write goes to the bus, writes win over reads.
  assign is_write = |mem_wr_i;
  assign bus_op   = mem_rd_i | is_write;
  assign maint_op = mem_flush_i | mem_invalidate_i | mem_writeback_i;
  assign local_op = ~bus_op & maint_op;

  // Request side; full is judged on the current count, ignoring a same-cycle pop.
  assign bus_req_o   = bus_op & (count < FULL_CNT) & ~local_pend_q;
  assign bus_we_o    = is_write;
  assign bus_addr_o  = word_align(mem_addr_i);
  assign bus_wdata_o = mem_data_wr_i;
  assign bus_be_o    = is_write ? mem_wr_i : BE_ALL;

  // Local ops wait for an empty FIFO so the two response sources never collide.
  assign bus_acc      = bus_req_o & bus_gnt_i;
  assign local_acc    = local_op & (count == '0) & ~local_pend_q;
  assign mem_accept_o = bus_acc | local_acc;

  assign push = bus_acc;
  assign pop  = bus_rvalid_i & (count != '0);

  dport_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DPORT_TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (mem_req_tag_i),
    .head_o  (head_tag),
    .count_o (count)
  );

  // Response register: one-cycle ack from either a bus pop or a local accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      tag_q        <= '0;
      local_pend_q <= 1'b0;
    end else begin
      ack_q        <= 1'b0;
      local_pend_q <= local_acc;
      if (pop) begin
        ack_q   <= 1'b1;
        rdata_q <= bus_rdata_i;
        err_q   <= bus_err_i;
        tag_q   <= head_tag;
      end else if (local_acc) begin
        ack_q   <= 1'b1;
        rdata_q <= '0;
        err_q   <= 1'b0;
        tag_q   <= mem_req_tag_i;
      end
    end
  end

  assign mem_ack_o      = ack_q;
  assign mem_error_o    = err_q;
  assign mem_data_rd_o  = rdata_q;
  assign mem_resp_tag_o = tag_q;

endmodule

// File: tb/tb_dport_ext_bridge.sv
// Self-checking bench for dport_ext_bridge: directed scenarios followed by a
// randomized run against a queue-based model of outstanding requests.
module tb_dport_ext_bridge;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr_i, mem_data_wr_i, mem_data_rd_o;
  logic        mem_rd_i, mem_cacheable_i;
  logic [3:0]  mem_wr_i;
  logic [10:0] mem_req_tag_i, mem_resp_tag_o;
  logic        mem_invalidate_i, mem_writeback_i, mem_flush_i;
  logic        mem_accept_o, mem_ack_o, mem_error_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state for the random run.
  logic [10:0] mq[$];
  bit          m_pend;

  dport_ext_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr_i(mem_addr_i), .mem_data_wr_i(mem_data_wr_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .mem_cacheable_i(mem_cacheable_i), .mem_req_tag_i(mem_req_tag_i),
    .mem_invalidate_i(mem_invalidate_i), .mem_writeback_i(mem_writeback_i),
    .mem_flush_i(mem_flush_i), .mem_data_rd_o(mem_data_rd_o), .mem_accept_o(mem_accept_o),
    .mem_ack_o(mem_ack_o), .mem_error_o(mem_error_o), .mem_resp_tag_o(mem_resp_tag_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  task automatic idle();
    mem_addr_i = '0; mem_data_wr_i = '0; mem_rd_i = 1'b0; mem_wr_i = '0;
    mem_cacheable_i = 1'b0; mem_req_tag_i = '0; mem_invalidate_i = 1'b0;
    mem_writeback_i = 1'b0; mem_flush_i = 1'b0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    n_vec++; if (mem_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b exp 0", mem_ack_o); end
    n_vec++; if (mem_error_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", mem_error_o); end
    n_vec++; if (mem_data_rd_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h exp 0", mem_data_rd_o); end
    n_vec++; if (mem_resp_tag_o !== 11'h0) begin n_err++; $display("FAIL reset_tag: got %h exp 0", mem_resp_tag_o); end
    n_vec++; if (bus_req_o !== 1'b0 || mem_accept_o !== 1'b0) begin n_err++; $display("FAIL reset_req: req %b acc %b exp 0 0", bus_req_o, mem_accept_o); end
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    idle();
    mem_rd_i = 1'b1; mem_addr_i = 32'h8000_0004; mem_req_tag_i = 11'h155; bus_gnt_i = 1'b1;
    #1;
    n_vec++; if (mem_accept_o !== 1'b1 || bus_req_o !== 1'b1) begin n_err++; $display("FAIL rd_accept: acc %b req %b exp 1 1", mem_accept_o, bus_req_o); end
    n_vec++; if (bus_be_o !== 4'hF || bus_we_o !== 1'b0) begin n_err++; $display("FAIL rd_be_we: be %h we %b exp F 0", bus_be_o, bus_we_o); end
    n_vec++; if (bus_addr_o !== 32'h8000_0004) begin n_err++; $display("FAIL rd_addr: got %h exp 80000004", bus_addr_o); end
    tick();
    idle();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    n_vec++; if (mem_ack_o !== 1'b0) begin n_err++; $display("FAIL rd_early_ack: got %b exp 0", mem_ack_o); end
    tick();
    idle();
    n_vec++; if (mem_ack_o !== 1'b1 || mem_data_rd_o !== 32'hDEAD_BEEF || mem_resp_tag_o !== 11'h155 || mem_error_o !== 1'b0)
      begin n_err++; $display("FAIL rd_resp: ack %b data %h tag %h err %b exp 1 deadbeef 155 0", mem_ack_o, mem_data_rd_o, mem_resp_tag_o, mem_error_o); end
    tick();
    n_vec++; if (mem_ack_o !== 1'b0) begin n_err++; $display("FAIL rd_ack_pulse: got %b exp 0", mem_ack_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      idle();
      mem_wr_i = 4'b0011; mem_req_tag_i = 11'(i); mem_addr_i = 32'h1000_0003 + 32'(i * 16);
      mem_data_wr_i = 32'hA0 + 32'(i); mem_rd_i = 1'b1; bus_gnt_i = 1'b1;
      #1;
      n_vec++; if (mem_accept_o !== 1'b1 || bus_we_o !== 1'b1 || bus_be_o !== 4'b0011)
        begin n_err++; $display("FAIL wr_accept_%0d: acc %b we %b be %h exp 1 1 3", i, mem_accept_o, bus_we_o, bus_be_o); end
      n_vec++; if (bus_addr_o !== 32'h1000_0000 + 32'(i * 16) || bus_wdata_o !== 32'hA0 + 32'(i))
        begin n_err++; $display("FAIL wr_addr_%0d: addr %h wdata %h", i, bus_addr_o, bus_wdata_o); end
      tick();
    end
    idle();
    mem_wr_i = 4'hF; mem_req_tag_i = 11'd5; bus_gnt_i = 1'b1;
    #1;
    n_vec++; if (bus_req_o !== 1'b0 || mem_accept_o !== 1'b0) begin n_err++; $display("FAIL wr_full: req %b acc %b exp 0 0", bus_req_o, mem_accept_o); end
    for (int i = 1; i <= 4; i++) begin
      idle();
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'(i);
      tick();
      n_vec++; if (mem_ack_o !== 1'b1 || mem_resp_tag_o !== 11'(i))
        begin n_err++; $display("FAIL wr_order_%0d: ack %b tag %h exp 1 %h", i, mem_ack_o, mem_resp_tag_o, i); end
    end
    idle();
    mem_wr_i = 4'hF; mem_req_tag_i = 11'd5; bus_gnt_i = 1'b1;
    #1;
    n_vec++; if (mem_accept_o !== 1'b1) begin n_err++; $display("FAIL wr_fifth: acc %b exp 1", mem_accept_o); end
    tick();
    idle(); bus_rvalid_i = 1'b1;
    tick();
    idle();
    n_vec++; if (mem_ack_o !== 1'b1 || mem_resp_tag_o !== 11'd5) begin n_err++; $display("FAIL wr_fifth_ack: ack %b tag %h exp 1 005", mem_ack_o, mem_resp_tag_o); end
    tick();
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) begin
      idle();
      mem_rd_i = 1'b1; mem_req_tag_i = 11'(10 + i); bus_gnt_i = 1'b1;
      tick();
    end
    idle();
    mem_rd_i = 1'b1; mem_req_tag_i = 11'd14; bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h10;
    #1;
    n_vec++; if (mem_accept_o !== 1'b0) begin n_err++; $display("FAIL full_same_cycle: acc %b exp 0", mem_accept_o); end
    tick();
    n_vec++; if (mem_ack_o !== 1'b1 || mem_resp_tag_o !== 11'd10) begin n_err++; $display("FAIL full_pop_ack: ack %b tag %h exp 1 00a", mem_ack_o, mem_resp_tag_o); end
    bus_rvalid_i = 1'b0;
    #1;
    n_vec++; if (mem_accept_o !== 1'b1) begin n_err++; $display("FAIL full_next_accept: acc %b exp 1", mem_accept_o); end
    tick();
    mem_req_tag_i = 11'd15;
    #1;
    n_vec++; if (bus_req_o !== 1'b0) begin n_err++; $display("FAIL full_again: req %b exp 0", bus_req_o); end
    for (int i = 0; i < 4; i++) begin
      idle(); bus_rvalid_i = 1'b1;
      tick();
      n_vec++; if (mem_ack_o !== 1'b1 || mem_resp_tag_o !== 11'(11 + i))
        begin n_err++; $display("FAIL full_drain_%0d: ack %b tag %h exp 1 %h", i, mem_ack_o, mem_resp_tag_o, 11 + i); end
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    mem_rd_i = 1'b1; mem_req_tag_i = 11'h020; bus_gnt_i = 1'b1;
    tick();
    idle();
    mem_flush_i = 1'b1; mem_req_tag_i = 11'h7FF; bus_gnt_i = 1'b1;
    #1;
    n_vec++; if (mem_accept_o !== 1'b0 || bus_req_o !== 1'b0) begin n_err++; $display("FAIL flush_blocked: acc %b req %b exp 0 0", mem_accept_o, bus_req_o); end
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    #1;
    n_vec++; if (mem_accept_o !== 1'b0) begin n_err++; $display("FAIL flush_blocked_rvalid: acc %b exp 0", mem_accept_o); end
    tick();
    bus_rvalid_i = 1'b0;
    n_vec++; if (mem_ack_o !== 1'b1 || mem_resp_tag_o !== 11'h020) begin n_err++; $display("FAIL flush_prior_ack: ack %b tag %h exp 1 020", mem_ack_o, mem_resp_tag_o); end
    n_vec++; if (mem_accept_o !== 1'b1 || bus_req_o !== 1'b0) begin n_err++; $display("FAIL flush_accept: acc %b req %b exp 1 0", mem_accept_o, bus_req_o); end
    tick();
    idle();
    n_vec++; if (mem_ack_o !== 1'b1 || mem_resp_tag_o !== 11'h7FF || mem_data_rd_o !== 32'h0 || mem_error_o !== 1'b0)
      begin n_err++; $display("FAIL flush_ack: ack %b tag %h data %h err %b exp 1 7ff 0 0", mem_ack_o, mem_resp_tag_o, mem_data_rd_o, mem_error_o); end
    tick();
    n_vec++; if (mem_ack_o !== 1'b0) begin n_err++; $display("FAIL flush_ack_pulse: got %b exp 0", mem_ack_o); end
  endtask

  task automatic test_error_stray();
    idle();
    mem_rd_i = 1'b1; mem_req_tag_i = 11'h0AA; bus_gnt_i = 1'b1;
    tick();
    idle();
    bus_rvalid_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'h55;
    tick();
    idle();
    n_vec++; if (mem_ack_o !== 1'b1 || mem_error_o !== 1'b1 || mem_resp_tag_o !== 11'h0AA)
      begin n_err++; $display("FAIL err_resp: ack %b err %b tag %h exp 1 1 0aa", mem_ack_o, mem_error_o, mem_resp_tag_o); end
    bus_rvalid_i = 1'b1;
    tick();
    idle();
    n_vec++; if (mem_ack_o !== 1'b0) begin n_err++; $display("FAIL stray_rvalid: ack %b exp 0", mem_ack_o); end
    mem_rd_i = 1'b1; mem_req_tag_i = 11'h033; bus_gnt_i = 1'b1;
    tick();
    idle();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFE_0001;
    tick();
    idle();
    n_vec++; if (mem_ack_o !== 1'b1 || mem_resp_tag_o !== 11'h033 || mem_error_o !== 1'b0 || mem_data_rd_o !== 32'hCAFE_0001)
      begin n_err++; $display("FAIL after_stray: ack %b tag %h err %b data %h exp 1 033 0 cafe0001", mem_ack_o, mem_resp_tag_o, mem_error_o, mem_data_rd_o); end
    tick();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      idle();
      mem_rd_i = 1'b1; mem_req_tag_i = 11'h100 + 11'(i); bus_gnt_i = 1'b1;
      tick();
    end
    idle();
    rst_n = 1'b0;
    #2;
    n_vec++; if (mem_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_ack: got %b exp 0", mem_ack_o); end
    rst_n = 1'b1;
    bus_rvalid_i = 1'b1;
    tick();
    n_vec++; if (mem_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_late_rvalid: ack %b exp 0", mem_ack_o); end
    idle();
    mem_rd_i = 1'b1; mem_req_tag_i = 11'h010; bus_gnt_i = 1'b1;
    #1;
    n_vec++; if (mem_accept_o !== 1'b1) begin n_err++; $display("FAIL rst_new_accept: acc %b exp 1", mem_accept_o); end
    tick();
    idle();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    tick();
    idle();
    n_vec++; if (mem_ack_o !== 1'b1 || mem_resp_tag_o !== 11'h010 || mem_data_rd_o !== 32'h0BAD_F00D)
      begin n_err++; $display("FAIL rst_new_resp: ack %b tag %h data %h exp 1 010 0badf00d", mem_ack_o, mem_resp_tag_o, mem_data_rd_o); end
    tick();
  endtask

  task automatic test_random();
    bit          bop, lop, e_req, e_acc, pop, x_ack, x_err;
    logic [10:0] x_tag;
    logic [31:0] x_data;
    logic [3:0]  e_be;
    mq.delete();
    m_pend = 1'b0;
    x_tag = '0; x_data = '0; x_err = 1'b0;
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 7);
      idle();
      mem_addr_i = $urandom; mem_data_wr_i = $urandom; mem_req_tag_i = 11'($urandom);
      mem_cacheable_i = 1'($urandom);
      case (k)
        0, 1: mem_rd_i = 1'b1;
        2, 3: mem_wr_i = 4'($urandom_range(1, 15));
        4: begin mem_rd_i = 1'b1; mem_wr_i = 4'($urandom_range(1, 15)); end
        5: case ($urandom_range(0, 2))
             0: mem_flush_i = 1'b1;
             1: mem_invalidate_i = 1'b1;
             default: mem_writeback_i = 1'b1;
           endcase
        6: begin mem_flush_i = 1'b1; mem_rd_i = 1'b1; end
        default: ;
      endcase
      bus_gnt_i = ($urandom_range(0, 3) != 0);
      bus_rvalid_i = ($urandom_range(0, 2) == 0);
      bus_rdata_i = $urandom;
      bus_err_i = ($urandom_range(0, 7) == 0);
      #1;
      bop   = mem_rd_i || (mem_wr_i != 4'h0);
      lop   = !bop && (mem_flush_i || mem_invalidate_i || mem_writeback_i);
      e_req = bop && (mq.size() < DEPTH) && !m_pend;
      e_acc = bop ? (e_req && bus_gnt_i) : (lop && mq.size() == 0 && !m_pend);
      e_be  = (mem_wr_i != 4'h0) ? mem_wr_i : 4'hF;
      n_vec++; if (bus_req_o !== e_req || mem_accept_o !== e_acc)
        begin n_err++; $display("FAIL rnd_req_%0d: req %b acc %b exp %b %b", i, bus_req_o, mem_accept_o, e_req, e_acc); end
      if (bop) begin
        n_vec++; if (bus_we_o !== (mem_wr_i != 4'h0) || bus_be_o !== e_be || bus_addr_o !== (mem_addr_i & 32'hFFFF_FFFC) || bus_wdata_o !== mem_data_wr_i)
          begin n_err++; $display("FAIL rnd_bus_%0d: we %b be %h addr %h wdata %h exp be %h", i, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, e_be); end
      end
      pop   = bus_rvalid_i && (mq.size() > 0);
      x_ack = 1'b0;
      if (pop) begin
        x_ack = 1'b1; x_tag = mq.pop_front(); x_data = bus_rdata_i; x_err = bus_err_i;
      end else if (lop && e_acc) begin
        x_ack = 1'b1; x_tag = mem_req_tag_i; x_data = '0; x_err = 1'b0;
      end
      if (bop && e_acc) mq.push_back(mem_req_tag_i);
      m_pend = lop && e_acc;
      tick();
      n_vec++; if (mem_ack_o !== x_ack) begin n_err++; $display("FAIL rnd_ack_%0d: got %b exp %b", i, mem_ack_o, x_ack); end
      if (x_ack) begin
        n_vec++; if (mem_resp_tag_o !== x_tag || mem_data_rd_o !== x_data || mem_error_o !== x_err)
          begin n_err++; $display("FAIL rnd_resp_%0d: tag %h data %h err %b exp %h %h %b", i, mem_resp_tag_o, mem_data_rd_o, mem_error_o, x_tag, x_data, x_err); end
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle();
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'(i);
      x_ack = (mq.size() > 0);
      if (x_ack) x_tag = mq.pop_front();
      tick();
      n_vec++; if (mem_ack_o !== x_ack) begin n_err++; $display("FAIL rnd_drain_ack_%0d: got %b exp %b", i, mem_ack_o, x_ack); end
      if (x_ack) begin
        n_vec++; if (mem_resp_tag_o !== x_tag) begin n_err++; $display("FAIL rnd_drain_tag_%0d: got %h exp %h", i, mem_resp_tag_o, x_tag); end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_full_pop_push();
    test_flush();
    test_error_stray();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
